// File: rtl/pipelined_decoder.sv
// rtl/pipelined_decoder.sv - registered RV32 main-control decoder with a flow-controlled FIFO
//
// Decodes each accepted instruction into its control bundle and queues it,
// together with the PC and register fields, in a DEPTH-entry circular FIFO.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous discard of all queued entries and illegal_seen
//   in_valid/in_ready     upstream handshake; in_instr, in_pc carried in
//   out_valid/out_ready   downstream handshake for the head entry
//   RegWrite..Illegal     1-bit control bits of the head entry
//   ImmSrc, ALUOp, ResultSrc  multi-bit control fields of the head entry
//   rd, rs1, rs2, funct3, funct7b5, pc  passthrough fields of the head entry
//   illegal_seen          sticky flag, set when an illegal entry is accepted
module pipelined_decoder #(
  parameter int DEPTH    = 2,
  parameter int PC_W     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            RegWrite,
  output logic            ALUSrc,
  output logic            MemWrite,
  output logic            Branch,
  output logic            Jump,
  output logic            PcOp,
  output logic            MulDiv,
  output logic            Illegal,
  output logic [2:0]      ImmSrc,
  output logic [1:0]      ALUOp,
  output logic [1:0]      ResultSrc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic            funct7b5,
  output logic [PC_W-1:0] pc,
  output logic            illegal_seen
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int CTRL_W  = 15;
  localparam int ENTRY_W = CTRL_W + 19 + PC_W;

  // Decoder outputs for the instruction currently offered on in_instr.
  logic       dec_reg_write, dec_alu_src, dec_mem_write, dec_branch;
  logic       dec_jump, dec_pc_op, dec_mul_div, dec_illegal;
  logic [2:0] dec_imm_src;
  logic [1:0] dec_alu_op, dec_result_src;

  logic [6:0] opcode;
  logic [6:0] funct7;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_mem_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_pc_op      = 1'b0;
    dec_mul_div    = 1'b0;
    dec_illegal    = 1'b0;
    dec_imm_src    = 3'b000;
    dec_alu_op     = 2'b00;
    dec_result_src = 2'b00;
    case (opcode)
      7'b0000011: begin  // LOAD
        dec_reg_write  = 1'b1;
        dec_imm_src    = 3'b001;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b01;
      end
      7'b0010011: begin  // OP-IMM
        dec_reg_write = 1'b1;
        dec_imm_src   = 3'b001;
        dec_alu_src   = 1'b1;
        dec_alu_op    = 2'b10;
      end
      7'b0100011: begin  // STORE
        dec_imm_src   = 3'b010;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      7'b0110011: begin  // OP, optionally RV32M
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec_reg_write = 1'b1;
          dec_alu_op    = 2'b10;
        end else if (ENABLE_M != 0 && funct7 == 7'b0000001) begin
          dec_reg_write = 1'b1;
          dec_alu_op    = 2'b11;
          dec_mul_div   = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b1100011: begin  // BRANCH
        dec_imm_src = 3'b011;
        dec_branch  = 1'b1;
        dec_alu_op  = 2'b01;
      end
      7'b0110111: begin  // LUI
        dec_reg_write = 1'b1;
        dec_imm_src   = 3'b100;
        dec_alu_src   = 1'b1;
      end
      7'b0010111: begin  // AUIPC
        dec_reg_write  = 1'b1;
        dec_imm_src    = 3'b100;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b11;
      end
      7'b1101111: begin  // JAL
        dec_reg_write  = 1'b1;
        dec_imm_src    = 3'b101;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b10;
        dec_jump       = 1'b1;
      end
      7'b1100111: begin  // JALR: target comes from rs1, hence PcOp
        dec_reg_write  = 1'b1;
        dec_imm_src    = 3'b001;
        dec_alu_src    = 1'b1;
        dec_result_src = 2'b10;
        dec_jump       = 1'b1;
        dec_alu_op     = 2'b10;
        dec_pc_op      = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  logic [ENTRY_W-1:0] entry_d;
  assign entry_d = {dec_reg_write, dec_alu_src, dec_mem_write, dec_branch,
                    dec_jump, dec_pc_op, dec_mul_div, dec_illegal,
                    dec_imm_src, dec_alu_op, dec_result_src,
                    in_instr[11:7], in_instr[19:15], in_instr[24:20],
                    in_instr[14:12], in_instr[30], in_pc};

  // FIFO state
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               illegal_seen_q, illegal_seen_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready comes from the registered count only, so a full FIFO never
  // accepts in the same cycle it pops.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    illegal_seen_d = illegal_seen_q;
    if (flush) begin
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      count_d        = '0;
      illegal_seen_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push && dec_illegal) illegal_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      illegal_seen_q <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      illegal_seen_q <= illegal_seen_d;
    end
  end

  // Payload storage needs no reset: it is only visible while out_valid is set.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  logic [ENTRY_W-1:0] head;
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign {RegWrite, ALUSrc, MemWrite, Branch, Jump, PcOp, MulDiv, Illegal,
          ImmSrc, ALUOp, ResultSrc, rd, rs1, rs2, funct3, funct7b5, pc} = head;

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_pipelined_decoder.sv
// tb/tb_pipelined_decoder.sv - self-checking bench for pipelined_decoder
module tb_pipelined_decoder;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid;
  logic        RegWrite, ALUSrc, MemWrite, Branch, Jump, PcOp, MulDiv, Illegal;
  logic [2:0]  ImmSrc, funct3;
  logic [1:0]  ALUOp, ResultSrc;
  logic [4:0]  rd, rs1, rs2;
  logic        funct7b5, illegal_seen;
  logic [31:0] pc;

  pipelined_decoder #(.DEPTH(DEPTH), .PC_W(32), .ENABLE_M(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .Branch(Branch),
    .Jump(Jump), .PcOp(PcOp), .MulDiv(MulDiv), .Illegal(Illegal),
    .ImmSrc(ImmSrc), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7b5(funct7b5), .pc(pc),
    .illegal_seen(illegal_seen)
  );

  // Second instance with RV32M disabled; it drains every cycle.
  logic        m0_flush, m0_in_valid, m0_in_ready, m0_out_valid;
  logic [31:0] m0_in_instr, m0_pc;
  logic        m0_rw, m0_as, m0_mw, m0_br, m0_j, m0_pco, m0_md, m0_ill;
  logic [2:0]  m0_imm, m0_f3;
  logic [1:0]  m0_aop, m0_res;
  logic [4:0]  m0_rd, m0_rs1, m0_rs2;
  logic        m0_f7b5, m0_illegal_seen;
  logic [14:0] m0_ctrl;

  pipelined_decoder #(.DEPTH(DEPTH), .PC_W(32), .ENABLE_M(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .flush(m0_flush),
    .in_valid(m0_in_valid), .in_ready(m0_in_ready), .in_instr(m0_in_instr), .in_pc(32'h0),
    .out_valid(m0_out_valid), .out_ready(1'b1),
    .RegWrite(m0_rw), .ALUSrc(m0_as), .MemWrite(m0_mw), .Branch(m0_br),
    .Jump(m0_j), .PcOp(m0_pco), .MulDiv(m0_md), .Illegal(m0_ill),
    .ImmSrc(m0_imm), .ALUOp(m0_aop), .ResultSrc(m0_res),
    .rd(m0_rd), .rs1(m0_rs1), .rs2(m0_rs2), .funct3(m0_f3), .funct7b5(m0_f7b5), .pc(m0_pc),
    .illegal_seen(m0_illegal_seen)
  );
  assign m0_ctrl = {m0_rw, m0_as, m0_mw, m0_br, m0_j, m0_pco, m0_md, m0_ill, m0_imm, m0_aop, m0_res};

  logic [65:0] dut_bus;
  assign dut_bus = {RegWrite, ALUSrc, MemWrite, Branch, Jump, PcOp, MulDiv, Illegal,
                    ImmSrc, ALUOp, ResultSrc, rd, rs1, rs2, funct3, funct7b5, pc};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Control bundle in the table's column order.
  function automatic logic [14:0] mk(input logic rw, input logic [2:0] imm, input logic asrc,
                                     input logic mw, input logic [1:0] res, input logic br,
                                     input logic j, input logic [1:0] aop, input logic pcop,
                                     input logic md, input logic ill);
    return {rw, asrc, mw, br, j, pcop, md, ill, imm, aop, res};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [14:0] ctrl;
  } vec_t;
  vec_t vt [13];

  logic [14:0] ill_ctrl;
  logic [14:0] cur_ctrl;

  // Scoreboard: push on accept, pop and compare on delivery.
  logic [65:0] sb [$];
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got unexpected entry %h expected none", dut_bus);
          end else begin
            chk("sb_head", dut_bus, sb.pop_front());
          end
        end
      end else begin
        chk("idle_zero", dut_bus, 66'h0);
      end
      if (in_valid && in_ready)
        sb.push_back({cur_ctrl, in_instr[11:7], in_instr[19:15], in_instr[24:20],
                      in_instr[14:12], in_instr[30], in_pc});
    end
  end

  task automatic send(input int idx, input logic [31:0] pcv);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_instr = vt[idx].instr;
    in_pc    = pcv;
    cur_ctrl = vt[idx].ctrl;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ill_ctrl = mk(0, 3'b000, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    vt[0]  = '{32'h00852283, mk(1, 3'b001, 1, 0, 2'b01, 0, 0, 2'b00, 0, 0, 0)};  // LOAD
    vt[1]  = '{32'h00A30313, mk(1, 3'b001, 1, 0, 2'b00, 0, 0, 2'b10, 0, 0, 0)};  // OP-IMM
    vt[2]  = '{32'h00B52423, mk(0, 3'b010, 1, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0)};  // STORE
    vt[3]  = '{32'h00B50533, mk(1, 3'b000, 0, 0, 2'b00, 0, 0, 2'b10, 0, 0, 0)};  // ADD
    vt[4]  = '{32'h40B50533, mk(1, 3'b000, 0, 0, 2'b00, 0, 0, 2'b10, 0, 0, 0)};  // SUB
    vt[5]  = '{32'h00B50463, mk(0, 3'b011, 0, 0, 2'b00, 1, 0, 2'b01, 0, 0, 0)};  // BRANCH
    vt[6]  = '{32'h123452B7, mk(1, 3'b100, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0)};  // LUI
    vt[7]  = '{32'h00001297, mk(1, 3'b100, 1, 0, 2'b11, 0, 0, 2'b00, 0, 0, 0)};  // AUIPC
    vt[8]  = '{32'h008000EF, mk(1, 3'b101, 1, 0, 2'b10, 0, 1, 2'b00, 0, 0, 0)};  // JAL
    vt[9]  = '{32'h000080E7, mk(1, 3'b001, 1, 0, 2'b10, 0, 1, 2'b10, 1, 0, 0)};  // JALR
    vt[10] = '{32'h02B50533, mk(1, 3'b000, 0, 0, 2'b00, 0, 0, 2'b11, 0, 1, 0)};  // MUL
    vt[11] = '{32'h04B50533, ill_ctrl};                                          // OP, bad funct7
    vt[12] = '{32'h0000007F, ill_ctrl};                                          // unknown opcode

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; cur_ctrl = '0;
    m0_flush = 1'b0; m0_in_valid = 1'b0; m0_in_instr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", dut_bus, 66'h0);
    chk("rst_illegal_seen", illegal_seen, 0);

    // RV32M disabled: MUL and unknown opcode are illegal
    chk("m0_seen_init", m0_illegal_seen, 0);
    m0_in_valid = 1'b1; m0_in_instr = 32'h02B50533;
    @(posedge clk); #1;
    chk("m0_mul_valid", m0_out_valid, 1);
    chk("m0_mul_ctrl", m0_ctrl, ill_ctrl);
    chk("m0_mul_rd", m0_rd, 5'd10);
    chk("m0_seen_rise", m0_illegal_seen, 1);
    m0_in_instr = 32'h0000007F;
    @(posedge clk); #1;
    chk("m0_7f_valid", m0_out_valid, 1);
    chk("m0_7f_ctrl", m0_ctrl, ill_ctrl);
    m0_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("m0_drained", m0_out_valid, 0);
    chk("m0_seen_hold", m0_illegal_seen, 1);
    m0_flush = 1'b1;
    @(posedge clk); #1;
    m0_flush = 1'b0;
    chk("m0_seen_flush", m0_illegal_seen, 0);

    // Stream the table at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(i, 32'h1000 + 32'(4 * i));
      chk("stream_latency", out_valid, 1);
      chk("stream_in_ready", in_ready, 1);
    end
    idle_cycles(2);
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_seen", illegal_seen, 1);

    // Backpressure: fill, overflow attempt, then drain through the wrap
    out_ready = 1'b0;
    send(5, 32'h2000);
    send(6, 32'h2004);
    in_valid = 1'b1; in_instr = vt[7].instr; in_pc = 32'h2008; cur_ctrl = vt[7].ctrl;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_head_pc", pc, 32'h2000);
    chk("full_head_rd", rd, vt[5].instr[11:7]);
    chk("full_head_branch", Branch, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("full_pop_in_ready", in_ready, 1);
    chk("full_pop_sb_size", sb.size(), 1);
    send(7, 32'h2008);
    send(8, 32'h200C);
    idle_cycles(3);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_out_valid", out_valid, 0);

    // Flush beats a simultaneous push and pop
    out_ready = 1'b0;
    send(12, 32'h3000);
    send(0, 32'h3004);
    in_valid = 1'b0;
    chk("pre_flush_valid", out_valid, 1);
    chk("pre_flush_seen", illegal_seen, 1);
    flush = 1'b1; in_valid = 1'b1; in_instr = vt[12].instr; in_pc = 32'h3008;
    cur_ctrl = vt[12].ctrl; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_seen", illegal_seen, 0);
    @(posedge clk); #1;
    chk("flush_not_stored", out_valid, 0);

    // Asynchronous reset with one entry queued
    out_ready = 1'b0;
    send(2, 32'h4000);
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_outputs", dut_bus, 66'h0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
